// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: decodes the EX/MEM memory bundle,
// runs one req/ack transaction per op and returns extended load data.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] EX_MEM_mem,
  input  logic [31:0] EX_MEM_addr,
  input  logic [31:0] EX_MEM_wdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        align_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               req_reg;
  logic               we_reg;
  logic [31:0]        addr_reg;
  logic [3:0]         be_reg;
  logic [31:0]        wdata_reg;
  logic               rd_reg;
  logic [1:0]         size_reg;
  logic               uns_reg;
  logic [1:0]         off_reg;
  logic               load_valid_reg;
  logic [31:0]        load_data_reg;
  logic               align_err_reg;
  logic               bus_err_reg;

  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        load_uns;
  logic [1:0]  off;
  logic        illegal;
  logic        misaligned;
  logic        launch;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [3:0]  byte_be;
  logic [31:0] ext_data;
  logic [7:0]  rd_lane [4];
  logic        reserved_unused;

  assign mem_read   = EX_MEM_mem[0];
  assign mem_write  = EX_MEM_mem[1];
  assign size       = EX_MEM_mem[3:2];
  assign load_uns   = EX_MEM_mem[4];
  assign off        = EX_MEM_addr[1:0];
  assign reserved_unused = ^EX_MEM_mem[11:5];

  assign illegal    = mem_read & mem_write;
  assign misaligned = (size == 2'b01) ? off[0] :
                      (size[1] ? (off != 2'b00) : 1'b0);
  assign launch     = (state_reg == IDLE) & (mem_read | mem_write) & ~illegal & ~misaligned;

  // Byte-lane selects for byte stores and byte-lane views of read data.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_be[gi] = (off == 2'(gi));
      assign rd_lane[gi] = dmem_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = EX_MEM_wdata;
    case (size)
      2'b00: begin
        be_next    = byte_be;
        wdata_next = {4{EX_MEM_wdata[7:0]}};
      end
      2'b01: begin
        be_next    = off[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{EX_MEM_wdata[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = EX_MEM_wdata;
      end
    endcase
  end

  // Extension uses the size/offset latched at launch, not the live bundle.
  always_comb begin
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    sel_byte = rd_lane[off_reg];
    sel_half = off_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ext_data = dmem_rdata;
    case (size_reg)
      2'b00:   ext_data = uns_reg ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      2'b01:   ext_data = uns_reg ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
      default: ext_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      req_reg        <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      be_reg         <= '0;
      wdata_reg      <= '0;
      rd_reg         <= 1'b0;
      size_reg       <= '0;
      uns_reg        <= 1'b0;
      off_reg        <= '0;
      load_valid_reg <= 1'b0;
      load_data_reg  <= '0;
      align_err_reg  <= 1'b0;
      bus_err_reg    <= 1'b0;
    end else begin
      load_valid_reg <= 1'b0;
      align_err_reg  <= 1'b0;
      bus_err_reg    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (mem_read | mem_write) begin
            if (illegal) begin
              bus_err_reg <= 1'b1;
            end else if (misaligned) begin
              align_err_reg <= 1'b1;
            end else begin
              req_reg   <= 1'b1;
              we_reg    <= mem_write;
              addr_reg  <= {EX_MEM_addr[31:2], 2'b00};
              be_reg    <= be_next;
              wdata_reg <= wdata_next;
              rd_reg    <= mem_read;
              size_reg  <= size;
              uns_reg   <= load_uns;
              off_reg   <= off;
              cnt_reg   <= '0;
              state_reg <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          // An ack on the final allowed cycle still counts as success.
          if (dmem_ack) begin
            req_reg        <= 1'b0;
            load_valid_reg <= rd_reg;
            if (rd_reg) load_data_reg <= ext_data;
            state_reg      <= DONE;
          end else if (cnt_reg == CNT_LAST) begin
            req_reg        <= 1'b0;
            bus_err_reg    <= 1'b1;
            load_valid_reg <= rd_reg;
            if (rd_reg) load_data_reg <= '0;
            state_reg      <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          req_reg   <= 1'b0;
        end
      endcase
    end
  end

  // Stall is gated by reset so a held bundle cannot stall the pipe during reset.
  assign mem_stall  = rst & ((state_reg == BUSY) | launch);
  assign dmem_req   = req_reg;
  assign dmem_we    = we_reg;
  assign dmem_addr  = addr_reg;
  assign dmem_be    = be_reg;
  assign dmem_wdata = wdata_reg;
  assign load_valid = load_valid_reg;
  assign load_data  = load_data_reg;
  assign align_err  = align_err_reg;
  assign bus_err    = bus_err_reg;

endmodule
